// File: rtl/pitch_pkg.sv
// Shared constants and types for the pitch-detection front end.
// The ring buffer holds RING_HOPS hops of HOP samples; one window spans WINDOW_HOPS hops.
package pitch_pkg;

  localparam int HOP         = 1024;
  localparam int WINDOW_HOPS = 4;
  localparam int RING_HOPS   = 5;
  localparam int RING_DEPTH  = HOP * RING_HOPS;
  localparam int SAMPLE_W    = 16;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [12:0]         ring_addr_t;
  typedef logic [2:0]          hop_idx_t;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } win_state_t;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up-counter with enable; o_wrap flags the enabled step that returns to zero.
module mod_counter #(
  parameter int MOD = 4,
  parameter int W   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_wrap
);

  logic [W-1:0] r_count;

  assign o_count = r_count;
  assign o_wrap  = i_en && (r_count == W'(MOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_wrap ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/input_windower.sv
// Writes the incoming sample stream into the hop ring buffer and issues a go pulse,
// with the first hop of the newest window, each time a hop completes once enough samples are resident.
module input_windower #(
  parameter int DATA_W      = 16,
  parameter int HOP         = 1024,
  parameter int WINDOW_HOPS = 4,
  parameter int RING_HOPS   = 5,
  parameter int ADDR_W      = 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     sample_in,
  input  logic                  sample_valid,
  input  logic                  consumer_ready,
  output logic [DATA_W-1:0]     ring_buf_data,
  output logic [ADDR_W-1:0]     ring_buf_addr,
  output logic                  ring_buf_wren,
  output logic [2:0]            window_start,
  output logic                  go_out,
  output logic [7:0]            dropped_windows,
  output pitch_pkg::win_state_t dbg_state
);

  localparam int OFF_W = $clog2(HOP);

  logic [OFF_W-1:0] w_off;
  logic             w_off_wrap;
  logic [2:0]       w_hop;
  logic             w_ring_wrap_unused;
  logic [3:0]       w_start_sum;
  logic [2:0]       w_next_start;
  logic             w_window_evt;

  logic [DATA_W-1:0]     r_data;
  logic [ADDR_W-1:0]     r_addr;
  logic                  r_wren;
  logic [2:0]            r_start;
  logic                  r_go;
  logic [7:0]            r_dropped;
  logic                  r_evt;
  logic [2:0]            r_evt_hop;
  logic [1:0]            r_hops_filled;
  pitch_pkg::win_state_t r_state;

  mod_counter #(.MOD(HOP), .W(OFF_W)) u_off_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (sample_valid),
    .o_count (w_off),
    .o_wrap  (w_off_wrap)
  );

  mod_counter #(.MOD(RING_HOPS), .W(3)) u_hop_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_off_wrap),
    .o_count (w_hop),
    .o_wrap  (w_ring_wrap_unused)
  );

  // The newest window ends at completed hop k and so begins at hop (k - WINDOW_HOPS + 1) mod RING_HOPS.
  assign w_start_sum  = {1'b0, r_evt_hop} + 4'(RING_HOPS - WINDOW_HOPS + 1);
  assign w_next_start = (w_start_sum >= 4'(RING_HOPS)) ? 3'(w_start_sum - 4'(RING_HOPS))
                                                       : w_start_sum[2:0];
  assign w_window_evt = r_evt && ((r_state == pitch_pkg::RUN) ||
                                  (r_hops_filled == 2'(WINDOW_HOPS - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data        <= '0;
      r_addr        <= '0;
      r_wren        <= 1'b0;
      r_start       <= '0;
      r_go          <= 1'b0;
      r_dropped     <= '0;
      r_evt         <= 1'b0;
      r_evt_hop     <= '0;
      r_hops_filled <= '0;
      r_state       <= pitch_pkg::FILL;
    end else begin
      r_wren <= sample_valid;
      if (sample_valid) begin
        r_addr <= ADDR_W'(w_hop * HOP + w_off);
        r_data <= sample_in;
      end
      // r_evt is visible alongside the hop's last write, so the decision lands one cycle after it.
      r_evt     <= w_off_wrap;
      r_evt_hop <= w_hop;
      r_go      <= 1'b0;

      if (r_evt && (r_state == pitch_pkg::FILL)) begin
        if (r_hops_filled == 2'(WINDOW_HOPS - 1)) begin
          r_state <= pitch_pkg::RUN;
        end else begin
          r_hops_filled <= r_hops_filled + 1'b1;
        end
      end

      if (w_window_evt) begin
        if (consumer_ready) begin
          r_go    <= 1'b1;
          r_start <= w_next_start;
        end else if (r_dropped != 8'hFF) begin
          r_dropped <= r_dropped + 1'b1;
        end
      end
    end
  end

  assign ring_buf_data   = r_data;
  assign ring_buf_addr   = r_addr;
  assign ring_buf_wren   = r_wren;
  assign window_start    = r_start;
  assign go_out          = r_go;
  assign dropped_windows = r_dropped;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_input_windower.sv
// Bench for input_windower: phase table plus write/go scoreboards, and a mid-hop reset sequence.
module tb_input_windower;

  logic        clk;
  logic        rst_n;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        consumer_ready;
  logic [15:0] ring_buf_data;
  logic [12:0] ring_buf_addr;
  logic        ring_buf_wren;
  logic [2:0]  window_start;
  logic        go_out;
  logic [7:0]  dropped_windows;
  pitch_pkg::win_state_t dbg_state;

  input_windower dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sample_in       (sample_in),
    .sample_valid    (sample_valid),
    .consumer_ready  (consumer_ready),
    .ring_buf_data   (ring_buf_data),
    .ring_buf_addr   (ring_buf_addr),
    .ring_buf_wren   (ring_buf_wren),
    .window_start    (window_start),
    .go_out          (go_out),
    .dropped_windows (dropped_windows),
    .dbg_state       (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // scoreboard queues: {addr, data} per write, window_start per issued go
  logic [28:0] exp_q[$];
  logic [2:0]  go_q[$];

  int          m_wr = 0;
  int          m_hops_filled = 0;
  bit          m_run = 0;
  logic [15:0] g_idx = 16'd0;
  int          go_seen = 0;
  bit          v_at_edge = 0;
  bit          prev_end = 0;

  always @(posedge clk) v_at_edge = sample_valid && rst_n;

  always @(negedge clk) begin
    logic [28:0] e;
    if (rst_n) begin
      check("wren_latency", int'(ring_buf_wren), int'(v_at_edge));
      if (ring_buf_wren) begin
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", int'(ring_buf_addr), int'(e[28:16]));
          check("wr_data", int'(ring_buf_data), int'(e[15:0]));
        end
      end
      if (go_out) begin
        go_seen++;
        check("go_after_hop_end_wren", int'(prev_end), 1);
        if (go_q.size() == 0) check("go_unexpected", 1, 0);
        else check("go_start", int'(window_start), int'(go_q.pop_front()));
      end
      prev_end = ring_buf_wren && (ring_buf_addr[9:0] == 10'h3FF);
    end
  end

  // driver tasks
  task automatic push_model(input logic [15:0] d);
    int k;
    bit evt;
    exp_q.push_back({13'(m_wr), d});
    if (m_wr % 1024 == 1023) begin
      k   = m_wr / 1024;
      evt = m_run;
      if (!m_run) begin
        if (m_hops_filled == 3) begin
          m_run = 1;
          evt   = 1;
        end else begin
          m_hops_filled++;
        end
      end
      if (evt && consumer_ready) go_q.push_back(3'((k + 2) % 5));
    end
    m_wr = (m_wr + 1) % 5120;
  endtask

  task automatic send(input int n, input bit sparse, input bit rand_data);
    logic [15:0] d;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sparse && ($urandom_range(0, 3) == 0)) begin
        sample_valid = 1'b0;
        @(negedge clk);
      end
      d = rand_data ? 16'($urandom) : g_idx;
      sample_valid = 1'b1;
      sample_in    = d;
      push_model(d);
      g_idx++;
    end
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    int n;
    bit ready;
    bit sparse;
    bit rand_data;
    int exp_gos;
    int exp_start;
    int exp_dropped;
    bit exp_run;
  } phase_t;

  phase_t ph[7];

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int base;
    ph[0] = '{4095,  1, 1, 0, 0,  0, 0, 0};
    ph[1] = '{1,     1, 0, 0, 1,  0, 0, 1};
    ph[2] = '{1024,  1, 1, 0, 2,  1, 0, 1};
    ph[3] = '{1024,  1, 0, 0, 3,  2, 0, 1};
    ph[4] = '{2048,  0, 1, 0, 3,  2, 2, 1};
    ph[5] = '{1024,  1, 0, 0, 4,  0, 2, 1};
    ph[6] = '{10240, 1, 0, 1, 14, 0, 2, 1};

    rst_n          = 1'b0;
    sample_valid   = 1'b0;
    sample_in      = 16'd0;
    consumer_ready = 1'b1;
    idle(3);
    check("rst_wren",    int'(ring_buf_wren), 0);
    check("rst_addr",    int'(ring_buf_addr), 0);
    check("rst_data",    int'(ring_buf_data), 0);
    check("rst_start",   int'(window_start), 0);
    check("rst_go",      int'(go_out), 0);
    check("rst_dropped", int'(dropped_windows), 0);
    check("rst_state",   int'(dbg_state), int'(pitch_pkg::FILL));
    rst_n = 1'b1;

    for (int p = 0; p < 7; p++) begin
      consumer_ready = ph[p].ready;
      idle(2);
      send(ph[p].n, ph[p].sparse, ph[p].rand_data);
      idle(4);
      check($sformatf("ph%0d_go_count", p), go_seen, ph[p].exp_gos);
      check($sformatf("ph%0d_start", p), int'(window_start), ph[p].exp_start);
      check($sformatf("ph%0d_dropped", p), int'(dropped_windows), ph[p].exp_dropped);
      check($sformatf("ph%0d_state", p), int'(dbg_state),
            ph[p].exp_run ? int'(pitch_pkg::RUN) : int'(pitch_pkg::FILL));
      check($sformatf("ph%0d_wr_drained", p), exp_q.size(), 0);
      check($sformatf("ph%0d_go_drained", p), go_q.size(), 0);
    end

    // 5000 more samples: hops 4,0,1,2 complete, then reset mid-hop with a write in flight
    consumer_ready = 1'b1;
    send(5000, 0, 0);
    idle(4);
    check("pre_reset_go_count", go_seen, 18);
    check("pre_reset_start", int'(window_start), 4);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_in    = 16'hBEEF;
    @(posedge clk);
    #1;
    check("pre_reset_wren", int'(ring_buf_wren), 1);
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    #1;
    check("mid_rst_wren",    int'(ring_buf_wren), 0);
    check("mid_rst_addr",    int'(ring_buf_addr), 0);
    check("mid_rst_data",    int'(ring_buf_data), 0);
    check("mid_rst_start",   int'(window_start), 0);
    check("mid_rst_go",      int'(go_out), 0);
    check("mid_rst_dropped", int'(dropped_windows), 0);
    check("mid_rst_state",   int'(dbg_state), int'(pitch_pkg::FILL));
    exp_q.delete();
    go_q.delete();
    m_wr          = 0;
    m_hops_filled = 0;
    m_run         = 0;
    prev_end      = 0;
    idle(2);
    rst_n = 1'b1;
    base  = go_seen;

    send(4095, 1, 0);
    idle(4);
    check("post_rst_no_go", go_seen, base);
    check("post_rst_fill",  int'(dbg_state), int'(pitch_pkg::FILL));
    send(1, 0, 0);
    idle(4);
    check("post_rst_go",    go_seen, base + 1);
    check("post_rst_start", int'(window_start), 0);
    check("post_rst_run",   int'(dbg_state), int'(pitch_pkg::RUN));
    check("post_rst_wr_drained", exp_q.size(), 0);
    check("post_rst_go_drained", go_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
